// File: rtl/mem_stage.sv
// mem_stage
// Memory-access pipeline stage sitting between execute and write-back.
// It latches the execute-stage bus, waits for the data-memory response when
// the instruction issued an access, aligns and extends load data and offers
// the finished result to write-back. It also gives decode the destination,
// forwarding value and load-use stall indication for the held instruction.
//
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   ws_allowin             : write-back can accept this cycle
//   ms_allowin             : this stage can accept from execute this cycle
//   es_to_ms_valid/_bus    : instruction offered by execute
//                            {mem_req, ld_op{w,hu,h,bu,b}, res_from_mem,
//                             gr_we, dest, alu_result, pc}
//   ms_to_ws_valid/_bus    : result offered to write-back
//                            {gr_we, dest, final_result, pc}
//   ms_to_ds_dest          : destination for hazard checks, 0 when none
//   ms_to_ds_result        : forwarding value (final_result)
//   ms_to_ds_load_pending  : a load is held here whose data has not arrived
//   data_sram_data_ok      : response strobe for the access issued in execute
//   data_sram_rdata        : read data, valid only with data_sram_data_ok
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 77,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_load_pending,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
    logic                       buf_valid;
    logic [31:0]                buf_data;

    logic        mem_req;
    logic        ld_w;
    logic        ld_hu;
    logic        ld_h;
    logic        ld_bu;
    logic        ld_b;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        ms_ready_go;
    logic        resp_take;
    logic [31:0] mem_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {mem_req, ld_w, ld_hu, ld_h, ld_bu, ld_b,
            res_from_mem, gr_we, dest, alu_result, pc} = es_bus_r;

    // The stage is ready once no response is owed, either because none was
    // requested, it was buffered earlier, or it is arriving this cycle.
    assign ms_ready_go    = !mem_req || buf_valid || data_sram_data_ok;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // A response only belongs to us while we hold a memory instruction that
    // has not already received its one response.
    assign resp_take = ms_valid && mem_req && !buf_valid && data_sram_data_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register needs no reset: it is only meaningful under ms_valid.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            es_bus_r <= es_to_ms_bus;
        end
    end

    // Read data is only valid in the data_ok cycle, so when write-back is
    // stalled at that moment the word is parked here until the instruction
    // leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_data  <= 32'd0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            buf_valid <= 1'b0;
        end else if (resp_take && !ws_allowin) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    assign mem_word = buf_valid ? buf_data : data_sram_rdata;

    // Halfword offset uses only address bit 1; misalignment is trapped
    // before this stage.
    always_comb begin
        sel_byte = mem_word[7:0];
        case (alu_result[1:0])
            2'd0: sel_byte = mem_word[7:0];
            2'd1: sel_byte = mem_word[15:8];
            2'd2: sel_byte = mem_word[23:16];
            2'd3: sel_byte = mem_word[31:24];
            default: sel_byte = mem_word[7:0];
        endcase
        sel_half = alu_result[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // An all-zero ld_op on a load falls back to the full word.
    always_comb begin
        load_data = mem_word;
        if (ld_b) begin
            load_data = {{24{sel_byte[7]}}, sel_byte};
        end else if (ld_bu) begin
            load_data = {24'd0, sel_byte};
        end else if (ld_h) begin
            load_data = {{16{sel_half[15]}}, sel_half};
        end else if (ld_hu) begin
            load_data = {16'd0, sel_half};
        end else if (ld_w) begin
            load_data = mem_word;
        end
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    assign ms_to_ws_bus          = {gr_we, dest, final_result, pc};
    assign ms_to_ds_dest         = dest & {5{ms_valid && gr_we}};
    assign ms_to_ds_result       = final_result;
    assign ms_to_ds_load_pending = ms_valid && res_from_mem && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed self-checking bench for mem_stage. Inputs change 1 ns after each
// rising edge and outputs are sampled mid-cycle, before the next edge.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [76:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [4:0]  ms_to_ds_dest;
    logic [31:0] ms_to_ds_result;
    logic        ms_to_ds_load_pending;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    int checks;
    int errors;

    mem_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .ws_allowin            (ws_allowin),
        .ms_allowin            (ms_allowin),
        .es_to_ms_valid        (es_to_ms_valid),
        .es_to_ms_bus          (es_to_ms_bus),
        .ms_to_ws_valid        (ms_to_ws_valid),
        .ms_to_ws_bus          (ms_to_ws_bus),
        .ms_to_ds_dest         (ms_to_ds_dest),
        .ms_to_ds_result       (ms_to_ds_result),
        .ms_to_ds_load_pending (ms_to_ds_load_pending),
        .data_sram_data_ok     (data_sram_data_ok),
        .data_sram_rdata       (data_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [4:0] OP_B  = 5'b00001;
    localparam logic [4:0] OP_BU = 5'b00010;
    localparam logic [4:0] OP_H  = 5'b00100;
    localparam logic [4:0] OP_HU = 5'b01000;
    localparam logic [4:0] OP_W  = 5'b10000;

    function automatic logic [76:0] mkBus(input logic mem_req, input logic [4:0] ld_op,
                                          input logic res_mem, input logic gr_we,
                                          input logic [4:0] dest, input logic [31:0] alu,
                                          input logic [31:0] pc);
        return {mem_req, ld_op, res_mem, gr_we, dest, alu, pc};
    endfunction

    task automatic checkOutput(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [76:0] bus, input logic ws,
                                 input logic dok, input logic [31:0] rdata);
        es_to_ms_valid    = valid;
        es_to_ms_bus      = bus;
        ws_allowin        = ws;
        data_sram_data_ok = dok;
        data_sram_rdata   = rdata;
        #2;
    endtask

    // Load enters, waits one cycle, then its data arrives with write-back open.
    task automatic runLoad(input string tag, input logic [4:0] ld_op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] pc;
        pc = 32'h1c00_0100;
        nextCycle();
        applyStimulus(1'b1, mkBus(1'b1, ld_op, 1'b1, 1'b1, 5'd7, addr, pc), 1'b1, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput({tag, "_pend"}, 70'(ms_to_ds_load_pending), 70'(1'b1));
        checkOutput({tag, "_wait"}, 70'(ms_to_ws_valid), 70'(1'b0));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, rdata);
        checkOutput({tag, "_pend0"}, 70'(ms_to_ds_load_pending), 70'(1'b0));
        checkOutput({tag, "_valid"}, 70'(ms_to_ws_valid), 70'(1'b1));
        checkOutput({tag, "_bus"}, ms_to_ws_bus, {1'b1, 5'd7, exp, pc});
        checkOutput({tag, "_fwd"}, 70'(ms_to_ds_result), 70'(exp));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput({tag, "_gone"}, 70'(ms_to_ws_valid), 70'(1'b0));
        checkOutput({tag, "_nobuf"}, 70'(dut.buf_valid), 70'(1'b0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("rst_valid", 70'(ms_to_ws_valid), 70'(1'b0));
        checkOutput("rst_allowin", 70'(ms_allowin), 70'(1'b1));
        checkOutput("rst_dest", 70'(ms_to_ds_dest), 70'(5'd0));
        checkOutput("rst_pend", 70'(ms_to_ds_load_pending), 70'(1'b0));
        checkOutput("rst_buf", 70'(dut.buf_valid), 70'(1'b0));
        reset = 1'b0;

        $display("[TB] ALU pass-through");
        nextCycle();
        applyStimulus(1'b1, mkBus(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h1c00_0000),
                      1'b1, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("alu_valid", 70'(ms_to_ws_valid), 70'(1'b1));
        checkOutput("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'h1c00_0000});
        checkOutput("alu_dest", 70'(ms_to_ds_dest), 70'(5'd5));
        checkOutput("alu_allowin", 70'(ms_allowin), 70'(1'b1));
        nextCycle();
        checkOutput("alu_gone", 70'(ms_to_ws_valid), 70'(1'b0));

        $display("[TB] load alignment and extension");
        runLoad("ldb",  OP_B,  32'h0000_1003, 32'h80FF_0011, 32'hFFFF_FF80);
        runLoad("ldbu", OP_BU, 32'h0000_1003, 32'h80FF_0011, 32'h0000_0080);
        runLoad("ldb1", OP_B,  32'h0000_1001, 32'h80FF_0011, 32'h0000_0000);
        runLoad("ldh",  OP_H,  32'h0000_1002, 32'h9ABC_1234, 32'hFFFF_9ABC);
        runLoad("ldhu", OP_HU, 32'h0000_1002, 32'h9ABC_1234, 32'h0000_9ABC);
        runLoad("ldh0", OP_H,  32'h0000_1000, 32'h9ABC_8234, 32'hFFFF_8234);
        runLoad("ldw",  OP_W,  32'h0000_1000, 32'h9ABC_1234, 32'h9ABC_1234);
        runLoad("ldz",  5'd0,  32'h0000_1001, 32'h1357_9BDF, 32'h1357_9BDF);

        $display("[TB] buffered response under write-back stall");
        nextCycle();
        applyStimulus(1'b1, mkBus(1'b1, OP_W, 1'b1, 1'b1, 5'd9, 32'h2000, 32'h1c00_0200),
                      1'b1, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("buf_rdy", 70'(ms_to_ws_valid), 70'(1'b1));
        checkOutput("buf_allow0", 70'(ms_allowin), 70'(1'b0));
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            // Second cycle carries a stray strobe that must not overwrite the buffer.
            applyStimulus(1'b0, '0, 1'b0, (i == 1), (i == 1) ? 32'h1111_1111 : 32'd0);
            checkOutput("buf_held", 70'(dut.buf_valid), 70'(1'b1));
            checkOutput("buf_allow", 70'(ms_allowin), 70'(1'b0));
            checkOutput("buf_res", 70'(ms_to_ds_result), 70'(32'hDEAD_BEEF));
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("buf_rel_bus", ms_to_ws_bus, {1'b1, 5'd9, 32'hDEAD_BEEF, 32'h1c00_0200});
        checkOutput("buf_rel_allow", 70'(ms_allowin), 70'(1'b1));
        nextCycle();
        checkOutput("buf_clr", 70'(dut.buf_valid), 70'(1'b0));
        checkOutput("buf_gone", 70'(ms_to_ws_valid), 70'(1'b0));

        $display("[TB] store with delayed response");
        nextCycle();
        applyStimulus(1'b1, mkBus(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 32'h3000, 32'h1c00_0300),
                      1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'hFFFF_FFFF);
            checkOutput("st_wait_v", 70'(ms_to_ws_valid), 70'(1'b0));
            checkOutput("st_wait_a", 70'(ms_allowin), 70'(1'b0));
            checkOutput("st_dest", 70'(ms_to_ds_dest), 70'(5'd0));
            checkOutput("st_pend", 70'(ms_to_ds_load_pending), 70'(1'b0));
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        checkOutput("st_valid", 70'(ms_to_ws_valid), 70'(1'b1));
        checkOutput("st_bus", ms_to_ws_bus, {1'b0, 5'd3, 32'h3000, 32'h1c00_0300});
        checkOutput("st_dest1", 70'(ms_to_ds_dest), 70'(5'd0));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("st_gone", 70'(ms_to_ws_valid), 70'(1'b0));

        $display("[TB] downstream stall and back-to-back entry");
        nextCycle();
        applyStimulus(1'b1, mkBus(1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 32'hAAAA_0001, 32'h1c00_0400),
                      1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b1, mkBus(1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 32'hBBBB_0002, 32'h1c00_0404),
                          1'b0, 1'b0, 32'd0);
            checkOutput("hold_bus", ms_to_ws_bus, {1'b1, 5'd10, 32'hAAAA_0001, 32'h1c00_0400});
            checkOutput("hold_allow", 70'(ms_allowin), 70'(1'b0));
            checkOutput("hold_valid", 70'(ms_to_ws_valid), 70'(1'b1));
        end
        ws_allowin = 1'b1;
        #1;
        checkOutput("b2b_allow", 70'(ms_allowin), 70'(1'b1));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("b2b_bus", ms_to_ws_bus, {1'b1, 5'd11, 32'hBBBB_0002, 32'h1c00_0404});
        checkOutput("b2b_valid", 70'(ms_to_ws_valid), 70'(1'b1));
        nextCycle();

        $display("[TB] reset during wait");
        applyStimulus(1'b1, mkBus(1'b1, OP_W, 1'b1, 1'b1, 5'd12, 32'h4000, 32'h1c00_0500),
                      1'b0, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h5555_AAAA);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'd0);
        checkOutput("rw_buf1", 70'(dut.buf_valid), 70'(1'b1));
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'd0);
        checkOutput("rw_mvalid", 70'(dut.ms_valid), 70'(1'b0));
        checkOutput("rw_buf0", 70'(dut.buf_valid), 70'(1'b0));
        checkOutput("rw_valid", 70'(ms_to_ws_valid), 70'(1'b0));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h7777_7777);
        checkOutput("rw_stray_v", 70'(ms_to_ws_valid), 70'(1'b0));
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'd0);
        checkOutput("rw_stray_buf", 70'(dut.buf_valid), 70'(1'b0));
        checkOutput("rw_stray_mv", 70'(dut.ms_valid), 70'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage (upstream) and the write-back stage (downstream).
- Latches the execute-stage bus and waits for the data-memory response when the instruction issued a memory access.
- Aligns and sign/zero-extends load data and presents a 70-bit result bus to write-back.
- Provides forwarding and load-use stall information to decode.

Parameters:
- ES_TO_MS_BUS_WD, 77, width of the execute-to-memory bus (`ES_TO_MS_BUS_WD in mycpu_head.v).
- MS_TO_WS_BUS_WD, 70, width of the memory-to-write-back bus (`MS_TO_WS_BUS_WD in mycpu_head.v).

Ports:
- clk  input  1  clock; one clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ws_allowin  input  1  write-back stage can accept this cycle.
- ms_allowin  output  1  this stage can accept from execute this cycle.
- es_to_ms_valid  input  1  execute presents a valid instruction.
- es_to_ms_bus  input  77  bit 76 mem_req; 75:71 ld_op one-hot {w,hu,h,bu,b}; 70 res_from_mem; 69 gr_we; 68:64 dest; 63:32 alu_result (memory address for accesses); 31:0 pc.
- ms_to_ws_valid  output  1  valid result offered to write-back.
- ms_to_ws_bus  output  70  69 gr_we; 68:64 dest; 63:32 final_result; 31:0 pc.
- ms_to_ds_dest  output  5  destination for hazard check, 0 when none.
- ms_to_ds_result  output  32  forwarding value (final_result).
- ms_to_ds_load_pending  output  1  load in this stage whose data is not yet available.
- data_sram_data_ok  input  1  response strobe for the access issued in execute.
- data_sram_rdata  input  32  read data, valid only with data_ok.

Behaviour:
- State:
  - ms_valid: reset 0.
  - bus register: loaded when es_to_ms_valid && ms_allowin; no reset required.
  - buf_valid: reset 0.
  - buf_data[31:0]: reset 0.
- Handshake:
  - ms_ready_go = !mem_req || buf_valid || data_sram_data_ok.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - When ms_allowin is high, ms_valid <= es_to_ms_valid.
- Response capture:
  - data_sram_data_ok is consumed only when ms_valid && mem_req && !buf_valid.
  - If consumed while ws_allowin = 0: buf_valid <= 1 and buf_data <= data_sram_rdata.
  - buf_valid clears when the instruction leaves (ms_to_ws_valid && ws_allowin).
  - data_ok in any other cycle is ignored; no state change.
  - Exactly one response per mem_req instruction; a second data_ok while buf_valid = 1 is ignored.
- Load data: mem_word = buf_valid ? buf_data : data_sram_rdata; a = alu_result[1:0].
  - ld.b / ld.bu: byte mem_word[8a+7:8a], sign- or zero-extended to 32 bits.
  - ld.h / ld.hu: half mem_word[16a[1]+15:16a[1]], sign- or zero-extended; a[0] is ignored because alignment is checked upstream.
  - ld.w: mem_word.
  - ld_op all-zero while res_from_mem = 1: result is mem_word.
- Result selection:
  - final_result = res_from_mem ? load_data : alu_result.
  - Stores: mem_req = 1, res_from_mem = 0; they wait for data_ok but pass alu_result through.
- Output bus: ms_to_ws_bus = {gr_we, dest, final_result, pc}, combinational from the registers.
- Forwarding:
  - ms_to_ds_dest = dest & {5{ms_valid && gr_we}}.
  - ms_to_ds_load_pending = ms_valid && res_from_mem && !ms_ready_go.
  - ms_to_ds_result is meaningful only when load_pending = 0.
- Latency:
  - Non-memory instruction: 1 cycle in stage when downstream is not stalled.
  - Memory instruction: leaves on the first cycle with ms_ready_go && ws_allowin; the same-cycle data_ok path adds 0 extra cycles.
- Boundaries:
  - Simultaneous data_ok and ws_allowin = 1: pass through, buffer not written.
  - Back-to-back instructions: a new instruction may enter the same cycle the old one leaves.
  - Reset mid-wait: ms_valid and buf_valid go to 0 at that edge; any later stray data_ok is ignored.
  - Downstream stalled with no memory access: the instruction holds and the bus register is unchanged.

Test Plan:
- ALU op: bus {mem_req=0, gr_we=1, dest=5, alu_result=0x1234, pc=0x1c000000}, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x1234,0x1c000000}, ms_to_ds_dest=5.
- ld.b at addr ...03, data_ok the cycle after entry with rdata=0x80FF_0011 -> load_pending=1 for one cycle, then final_result=0xFFFFFF80; ld.bu with the same inputs -> 0x00000080.
- ld.h at addr ...02, rdata=0x9ABC_1234 -> 0xFFFF9ABC; ld.hu -> 0x00009ABC; ld.w -> 0x9ABC1234.
- ld.w, data_ok=1 with rdata=0xDEADBEEF while ws_allowin=0 for 3 cycles, rdata then driven 0 -> buf_valid=1, ms_allowin=0, then final_result=0xDEADBEEF on release and buf_valid clears.
- Store (mem_req=1, res_from_mem=0, gr_we=0) with data_ok delayed 4 cycles -> ms_to_ws_valid=0 and ms_allowin=0 until data_ok; ms_to_ds_dest=0 throughout.
- Reset asserted while a load waits, then stray data_ok -> ms_valid=0, buf_valid=0, ms_to_ws_valid stays 0.
